// File: rtl/bht_update_sched.sv
// rtl/bht_update_sched.sv - queues resolved branches and issues one BHT update per cycle
// Optional macro BHT_UPD_BYPASS_EN: an outcome arriving at an empty, unconflicted queue updates in the same cycle.
module bht_update_sched #(
  parameter int INDEX_WIDTH = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_DEFER   = 3
) (
  input  logic                           i_clk,
  input  logic                           i_arst,
  input  logic                           i_res_valid,
  output logic                           o_res_ready,
  input  logic                           i_res_taken,
  input  logic [INDEX_WIDTH-1:0]         i_res_index,
  input  logic                           i_fetch_valid,
  input  logic [INDEX_WIDTH-1:0]         i_fetch_index,
  input  logic                           i_stall,
  input  logic                           i_flush,
  output logic                           o_bht_update,
  output logic                           o_branch_taken,
  output logic [INDEX_WIDTH-1:0]         o_set_index_exec,
  output logic [$clog2(FIFO_DEPTH):0]    o_pending_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(MAX_DEFER + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DEFER} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     r_fifo_taken [FIFO_DEPTH];
  logic [INDEX_WIDTH-1:0]   r_fifo_index [FIFO_DEPTH];
  logic [PW-1:0]            r_wptr;
  logic [PW-1:0]            r_rptr;
  logic [CW-1:0]            r_cnt;
  logic [DW-1:0]            r_defer_cnt;

  logic                     w_empty;
  logic                     w_full;
  logic                     w_head_taken;
  logic [INDEX_WIDTH-1:0]   w_head_index;
  logic                     w_conflict;
  logic                     w_defer_sat;
  logic                     w_issue;
  logic                     w_blocked;
  logic                     w_bypass;
  logic                     w_push;

  assign w_empty      = (r_cnt == '0);
  assign w_full       = (r_cnt == CW'(FIFO_DEPTH));
  assign w_head_taken = r_fifo_taken[r_rptr];
  assign w_head_index = r_fifo_index[r_rptr];
  assign w_conflict   = i_fetch_valid & (i_fetch_index == w_head_index);
  assign w_defer_sat  = (r_defer_cnt == DW'(MAX_DEFER));
  assign w_issue      = ~w_empty & ~i_stall & ~i_flush & (~w_conflict | w_defer_sat);
  assign w_blocked    = ~w_empty & ~i_stall & ~i_flush & w_conflict & ~w_defer_sat;

`ifdef BHT_UPD_BYPASS_EN
  assign w_bypass = w_empty & i_res_valid & ~i_stall & ~i_flush &
                    ~(i_fetch_valid & (i_fetch_index == i_res_index));
`else
  assign w_bypass = 1'b0;
`endif

  // No pop-through: a full queue refuses input even in a cycle that pops.
  assign o_res_ready   = ~w_full & ~i_flush;
  assign w_push        = i_res_valid & o_res_ready & ~w_bypass;
  assign o_pending_cnt = r_cnt;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_taken[r_wptr] <= i_res_taken;
      r_fifo_index[r_wptr] <= i_res_index;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_defer_cnt <= '0;
    end else if (i_flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_defer_cnt <= '0;
    end else begin
      if (w_push)  r_wptr <= r_wptr + PW'(1);
      if (w_issue) r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_issue})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_issue)        r_defer_cnt <= '0;
      else if (w_blocked) r_defer_cnt <= r_defer_cnt + DW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_push) w_state_next = S_ACTIVE;
        S_ACTIVE,
        S_DEFER: begin
          if (w_issue && (r_cnt == CW'(1)) && !w_push) w_state_next = S_IDLE;
          else if (w_issue)                            w_state_next = S_ACTIVE;
          else if (w_blocked)                          w_state_next = S_DEFER;
        end
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // The head fields are shown whenever the queue holds something, even while held back.
  always_comb begin
    o_bht_update     = w_issue | w_bypass;
    o_branch_taken   = 1'b0;
    o_set_index_exec = '0;
    if (w_bypass) begin
      o_branch_taken   = i_res_taken;
      o_set_index_exec = i_res_index;
    end else if (r_state != S_IDLE) begin
      o_branch_taken   = w_head_taken;
      o_set_index_exec = w_head_index;
    end
  end

endmodule

// File: tb/tb_bht_update_sched.sv
// tb/tb_bht_update_sched.sv - scoreboard bench for bht_update_sched
module tb_bht_update_sched;
  localparam int IW = 6;
`ifdef BHT_UPD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arst;
  logic          res_valid, res_ready, res_taken;
  logic [IW-1:0] res_index;
  logic          fetch_valid;
  logic [IW-1:0] fetch_index;
  logic          stall, flush;
  logic          bht_update, branch_taken;
  logic [IW-1:0] set_index;
  logic [2:0]    pending;

  int            n_cmp = 0;
  int            n_fail = 0;
  int            n_upd = 0;
  logic [IW:0]   sb[$];
  logic [IW:0]   exp_e;

  always #5 clk = ~clk;

  bht_update_sched #(.INDEX_WIDTH(IW), .FIFO_DEPTH(4), .MAX_DEFER(3)) dut (
    .i_clk(clk), .i_arst(arst),
    .i_res_valid(res_valid), .o_res_ready(res_ready),
    .i_res_taken(res_taken), .i_res_index(res_index),
    .i_fetch_valid(fetch_valid), .i_fetch_index(fetch_index),
    .i_stall(stall), .i_flush(flush),
    .o_bht_update(bht_update), .o_branch_taken(branch_taken),
    .o_set_index_exec(set_index), .o_pending_cnt(pending)
  );

  // Every issued update must match the oldest outstanding expected entry.
  always @(negedge clk) begin
    #2;
    if (bht_update === 1'b1) begin
      n_upd++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got update taken=%0b idx=%0d, required no update", branch_taken, set_index);
      end else begin
        exp_e = sb.pop_front();
        if ({branch_taken, set_index} !== exp_e) begin
          n_fail++;
          $display("FAIL sb_data: got taken=%0b idx=%0d, required taken=%0b idx=%0d",
                   branch_taken, set_index, exp_e[IW], exp_e[IW-1:0]);
        end
      end
    end
  end

  task automatic idle_inputs;
    res_valid = 0; res_taken = 0; res_index = '0;
    fetch_valid = 0; fetch_index = '0; stall = 0; flush = 0;
  endtask

  task automatic test_reset;
    arst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bht_update !== 1'b0) begin n_fail++; $display("FAIL rst_update: got %0b, required 0", bht_update); end
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL rst_pending: got %0d, required 0", pending); end
    n_cmp++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b, required 1", res_ready); end
    n_cmp++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken: got %0b, required 0", branch_taken); end
    n_cmp++; if (set_index !== '0) begin n_fail++; $display("FAIL rst_index: got %0d, required 0", set_index); end
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_single;
    @(negedge clk);
    res_valid = 1; res_taken = 1; res_index = 6'd5;
    sb.push_back({1'b1, 6'd5});
    #1;
    n_cmp++; if (bht_update !== BYP) begin n_fail++; $display("FAIL single_c0_update: got %0b, required %0b", bht_update, BYP); end
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL single_c0_pending: got %0d, required 0", pending); end
    @(negedge clk);
    res_valid = 0;
    #1;
    n_cmp++; if (bht_update !== !BYP) begin n_fail++; $display("FAIL single_c1_update: got %0b, required %0b", bht_update, !BYP); end
    n_cmp++; if (pending !== {2'b0, !BYP}) begin n_fail++; $display("FAIL single_c1_pending: got %0d, required %0d", pending, !BYP); end
    @(negedge clk);
    #1;
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL single_c2_pending: got %0d, required 0", pending); end
    n_cmp++; if (bht_update !== 1'b0) begin n_fail++; $display("FAIL single_c2_update: got %0b, required 0", bht_update); end
  endtask

  task automatic test_fill_stall;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      stall = 1; res_valid = 1; res_taken = i[0]; res_index = IW'(20 + i);
      sb.push_back({i[0], IW'(20 + i)});
    end
    @(negedge clk);
    res_valid = 1; res_taken = 1; res_index = 6'd63;
    #1;
    n_cmp++; if (pending !== 3'd4) begin n_fail++; $display("FAIL fill_pending: got %0d, required 4", pending); end
    n_cmp++; if (res_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %0b, required 0", res_ready); end
    n_cmp++; if (bht_update !== 1'b0) begin n_fail++; $display("FAIL fill_stall_update: got %0b, required 0", bht_update); end
    @(negedge clk);
    res_valid = 0; stall = 0;
    #1;
    n_cmp++; if (pending !== 3'd4) begin n_fail++; $display("FAIL fill_fifth_rejected: got %0d, required 4", pending); end
    n_cmp++; if (res_ready !== 1'b0) begin n_fail++; $display("FAIL fill_no_popthru: got %0b, required 0", res_ready); end
    n_cmp++; if (bht_update !== 1'b1) begin n_fail++; $display("FAIL drain_0: got %0b, required 1", bht_update); end
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_cmp++; if (bht_update !== 1'b1) begin n_fail++; $display("FAIL drain_%0d: got %0b, required 1", i, bht_update); end
      n_cmp++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready_%0d: got %0b, required 1", i, res_ready); end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL drain_end_pending: got %0d, required 0", pending); end
  endtask

  task automatic test_defer_max;
    @(negedge clk);
    fetch_valid = 1; fetch_index = 6'd9;
    res_valid = 1; res_taken = 0; res_index = 6'd9;
    sb.push_back({1'b0, 6'd9});
    #1;
    n_cmp++; if (bht_update !== 1'b0) begin n_fail++; $display("FAIL defer_push_update: got %0b, required 0", bht_update); end
    // Conflict, conflict, stall (holds count), conflict, then forced issue.
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      res_valid = 0;
      stall = (c == 3);
      #1;
      n_cmp++;
      if (bht_update !== (c == 5)) begin
        n_fail++; $display("FAIL defer_c%0d: got update %0b, required %0b", c, bht_update, (c == 5));
      end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL defer_end_pending: got %0d, required 0", pending); end
  endtask

  task automatic test_defer_release;
    @(negedge clk);
    fetch_valid = 1; fetch_index = 6'd9;
    res_valid = 1; res_taken = 1; res_index = 6'd9;
    sb.push_back({1'b1, 6'd9});
    @(negedge clk);
    res_valid = 0;
    #1;
    n_cmp++; if (bht_update !== 1'b0) begin n_fail++; $display("FAIL release_conflict: got %0b, required 0", bht_update); end
    @(negedge clk);
    fetch_index = 6'd10;
    #1;
    n_cmp++; if (bht_update !== 1'b1) begin n_fail++; $display("FAIL release_issue: got %0b, required 1", bht_update); end
    @(negedge clk);
    fetch_valid = 0;
    #1;
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL release_pending: got %0d, required 0", pending); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1; res_valid = 1; res_taken = ~i[0]; res_index = IW'(40 + i);
      sb.push_back({~i[0], IW'(40 + i)});
    end
    @(negedge clk);
    res_valid = 0;
    #1;
    n_cmp++; if (pending !== 3'd3) begin n_fail++; $display("FAIL flush_pre_pending: got %0d, required 3", pending); end
    @(negedge clk);
    flush = 1; stall = 0; res_valid = 1; res_index = 6'd33;
    sb.delete();
    #1;
    n_cmp++; if (bht_update !== 1'b0) begin n_fail++; $display("FAIL flush_update: got %0b, required 0", bht_update); end
    n_cmp++; if (res_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b, required 0", res_ready); end
    @(negedge clk);
    flush = 0; res_valid = 0;
    #1;
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL flush_post_pending: got %0d, required 0", pending); end
    n_cmp++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL flush_post_ready: got %0b, required 1", res_ready); end
    repeat (2) begin
      @(negedge clk);
      #1;
      n_cmp++; if (bht_update !== 1'b0) begin n_fail++; $display("FAIL flush_idle_update: got %0b, required 0", bht_update); end
    end
  endtask

  task automatic test_arst;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1; res_valid = 1; res_taken = 1; res_index = IW'(50 + i);
      sb.push_back({1'b1, IW'(50 + i)});
    end
    @(negedge clk);
    stall = 0; res_valid = 0;
    #1;
    n_cmp++; if (bht_update !== 1'b1) begin n_fail++; $display("FAIL arst_first_issue: got %0b, required 1", bht_update); end
    @(negedge clk);
    #1;
    n_cmp++; if (pending !== 3'd2) begin n_fail++; $display("FAIL arst_pre_pending: got %0d, required 2", pending); end
    arst = 1;
    sb.delete();
    #1;
    n_cmp++; if (bht_update !== 1'b0) begin n_fail++; $display("FAIL arst_update: got %0b, required 0", bht_update); end
    n_cmp++; if (pending !== 3'd0) begin n_fail++; $display("FAIL arst_pending: got %0d, required 0", pending); end
    n_cmp++; if (res_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %0b, required 1", res_ready); end
    @(negedge clk);
    arst = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      n_cmp++; if (bht_update !== 1'b0) begin n_fail++; $display("FAIL arst_idle_update: got %0b, required 0", bht_update); end
    end
  endtask

  task automatic test_back_to_back;
    int start;
    int budget;
    logic          t;
    logic [IW-1:0] x;
    start = n_upd;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      t = 1'($urandom);
      x = IW'($urandom_range(0, 63));
      res_valid = 1; res_taken = t; res_index = x;
      sb.push_back({t, x});
      #1;
      if (i > 0) begin
        n_cmp++;
        if (pending !== {2'b0, !BYP}) begin n_fail++; $display("FAIL b2b_pending_%0d: got %0d, required %0d", i, pending, !BYP); end
      end
    end
    @(negedge clk);
    res_valid = 0;
    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    #3;
    n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_drain_timeout: got %0d outstanding, required 0", sb.size()); end
    n_cmp++; if (n_upd - start != 6) begin n_fail++; $display("FAIL b2b_count: got %0d updates, required 6", n_upd - start); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_defer_max();
    test_defer_release();
    test_flush();
    test_arst();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
